// File: rtl/t_word_server.sv
// rtl/t_word_server.sv - word store loaded by a host, then served to a processor as a circular buffer
// Optional sticky protocol-error flag enabled by defining T_WORD_SERVER_ERR_EN.
module t_word_server #(
    parameter int WORD_W    = 64,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = 4,
    parameter int TSIZE_W   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load_start,
    input  logic [TSIZE_W-1:0] i_load_t_size,
    input  logic               i_load_valid,
    input  logic [WORD_W-1:0]  i_load_data,
    input  logic               i_load_last,
    output logic               o_load_ready,
    input  logic               i_sram_request,
    output logic [WORD_W-1:0]  o_request_data,
    output logic               o_request_valid,
    input  logic               i_sram_send,
    input  logic [WORD_W-1:0]  i_send_data,
    output logic [TSIZE_W-1:0] o_T_size,
    output logic               o_ready,
    input  logic               i_clear,
    output logic               o_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE} state_t;

    localparam logic [DEPTH_LOG:0]   FULL    = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG+1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

    state_t             state;
    logic [DEPTH_LOG:0] cnt;
    logic [DEPTH_LOG-1:0] rp;
    logic [DEPTH_LOG-1:0] wp;
    logic [WORD_W-1:0]  mem [DEPTH];

    logic                 serving;
    logic                 load_accept;
    logic                 serve_read;
    logic                 serve_write;
    logic                 mem_we;
    logic [DEPTH_LOG-1:0] mem_waddr;
    logic [WORD_W-1:0]    mem_wdata;

    // Pointers wrap at the loaded word count, not at DEPTH.
    function automatic logic [DEPTH_LOG-1:0] next_ptr(input logic [DEPTH_LOG-1:0] p,
                                                      input logic [DEPTH_LOG:0]   n);
        if ({1'b0, p} == n - CNT_ONE)
            return '0;
        return p + PTR_ONE;
    endfunction

    assign o_ready      = (state == S_SERVE);
    assign o_load_ready = (state == S_LOAD) && (cnt < FULL);
    assign serving      = (state == S_SERVE) && (cnt != '0);
    assign load_accept  = (state == S_LOAD) && i_load_valid && o_load_ready && !i_clear;
    assign serve_read   = serving && i_sram_request && !i_clear;
    assign serve_write  = serving && i_sram_send && !i_clear;

    assign mem_we    = load_accept || serve_write;
    assign mem_waddr = load_accept ? cnt[DEPTH_LOG-1:0] : wp;
    assign mem_wdata = load_accept ? i_load_data : i_send_data;

    // Storage has no reset so contents survive rst and i_clear.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            cnt             <= '0;
            rp              <= '0;
            wp              <= '0;
            o_T_size        <= '0;
            o_request_data  <= '0;
            o_request_valid <= 1'b0;
        end else begin
            // A read sees mem before this cycle's writeback lands.
            o_request_valid <= i_sram_request && !i_clear;
            o_request_data  <= serve_read ? mem[rp] : '0;
            if (serve_read)
                rp <= next_ptr(rp, cnt);
            if (serve_write)
                wp <= next_ptr(wp, cnt);

            case (state)
                S_IDLE: begin
                    if (i_clear) begin
                        cnt <= '0;
                        rp  <= '0;
                        wp  <= '0;
                    end else if (i_load_start) begin
                        state    <= S_LOAD;
                        o_T_size <= i_load_t_size;
                        cnt      <= '0;
                        rp       <= '0;
                        wp       <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_clear) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        rp    <= '0;
                        wp    <= '0;
                    end else if (load_accept) begin
                        cnt <= cnt + CNT_ONE;
                        if (i_load_last)
                            state <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (i_clear) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        rp    <= '0;
                        wp    <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef T_WORD_SERVER_ERR_EN
    logic err_event;

    assign err_event = !i_clear &&
                       (((i_sram_request || i_sram_send) && !serving) ||
                        ((state == S_LOAD) && i_load_valid && !o_load_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_err <= 1'b0;
        else if ((state == S_IDLE) && i_load_start && !i_clear)
            o_err <= 1'b0;
        else if (err_event)
            o_err <= 1'b1;
    end
`else
    assign o_err = 1'b0;
`endif

endmodule
